// File: rtl/alu_sequencer_if.sv
// Bus between the sequencer, its program ROM and the alu.
// The sequencer connects as slave; the ROM/alu side (or a bench) as master.
interface alu_sequencer_if #(
  parameter int IWIDTH = 4,
  parameter int DWIDTH = 4,
  parameter int AWIDTH = 4
);
  logic                     START;
  logic                     EN;
  logic [AWIDTH-1:0]        PROG_ADDR;
  logic [IWIDTH+DWIDTH-1:0] PROG_DATA;
  logic [IWIDTH-1:0]        ALU_INSTR;
  logic [DWIDTH-1:0]        ALU_A;
  logic [DWIDTH-1:0]        ALU_B;
  logic [DWIDTH-1:0]        ALU_OUT;
  logic [DWIDTH-1:0]        ACC;
  logic                     ZF;
  logic                     HALTED;

  modport slave (
    input  START, EN, PROG_DATA, ALU_OUT,
    output PROG_ADDR, ALU_INSTR, ALU_A, ALU_B, ACC, ZF, HALTED
  );

  modport master (
    output START, EN, PROG_DATA, ALU_OUT,
    input  PROG_ADDR, ALU_INSTR, ALU_A, ALU_B, ACC, ZF, HALTED
  );
endinterface

// File: rtl/alu_sequencer.sv
// Single-cycle control stage: fetches from ROM, drives the alu, writes back to ACC,
// and handles JMP/JZ/NOP/HLT locally.
module alu_sequencer #(
  parameter int IWIDTH = 4,
  parameter int DWIDTH = 4,
  parameter int AWIDTH = 4
) (
  input logic           CLK,
  input logic           RST,
  alu_sequencer_if.slave bus
);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_HALT} state_t;

  localparam logic [IWIDTH-1:0] OP_ALU_LAST = IWIDTH'(10);
  localparam logic [IWIDTH-1:0] OP_JMP      = IWIDTH'(11);
  localparam logic [IWIDTH-1:0] OP_JZ       = IWIDTH'(12);
  localparam logic [IWIDTH-1:0] OP_HLT      = IWIDTH'(15);

  state_t            r_state;
  logic [AWIDTH-1:0] r_pc;
  logic [DWIDTH-1:0] r_acc;
  logic              r_zf;
  logic              r_halted;

  logic [IWIDTH-1:0] w_opcode;
  logic [DWIDTH-1:0] w_operand;
  logic              w_is_alu;
  logic [AWIDTH-1:0] w_pc_inc;
  logic [AWIDTH-1:0] w_target;

  assign w_opcode  = bus.PROG_DATA[IWIDTH+DWIDTH-1:DWIDTH];
  assign w_operand = bus.PROG_DATA[DWIDTH-1:0];
  assign w_is_alu  = (w_opcode <= OP_ALU_LAST);
  assign w_pc_inc  = r_pc + AWIDTH'(1);
  assign w_target  = w_operand[AWIDTH-1:0];

  // Non-alu opcodes present 0 to the alu; its result is discarded for them.
  assign bus.ALU_INSTR = w_is_alu ? w_opcode : '0;
  assign bus.ALU_A     = r_acc;
  assign bus.ALU_B     = w_operand;
  assign bus.PROG_ADDR = r_pc;
  assign bus.ACC       = r_acc;
  assign bus.ZF        = r_zf;
  assign bus.HALTED    = r_halted;

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      r_state  <= S_IDLE;
      r_pc     <= '0;
      r_acc    <= '0;
      r_zf     <= 1'b0;
      r_halted <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (bus.START) r_state <= S_RUN;
        end
        S_RUN: begin
          if (bus.EN) begin
            if (w_is_alu) begin
              r_acc <= bus.ALU_OUT;
              r_zf  <= (bus.ALU_OUT == '0);
              r_pc  <= w_pc_inc;
            end else begin
              case (w_opcode)
                OP_JMP: r_pc <= w_target;
                OP_JZ:  r_pc <= r_zf ? w_target : w_pc_inc;
                OP_HLT: begin
                  r_state  <= S_HALT;
                  r_halted <= 1'b1;
                end
                default: r_pc <= w_pc_inc;  // NOP and reserved
              endcase
            end
          end
        end
        S_HALT: begin
          // Restart keeps ACC/ZF so a program can resume on prior results.
          if (bus.START) begin
            r_state  <= S_RUN;
            r_pc     <= '0;
            r_halted <= 1'b0;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_sequencer.sv
// Directed bench for alu_sequencer with a behavioural ROM and alu.
module tb_alu_sequencer;

  logic CLK = 1'b0;
  logic RST;
  always #5 CLK = ~CLK;

  alu_sequencer_if #(.IWIDTH(4), .DWIDTH(4), .AWIDTH(4)) bus ();

  alu_sequencer #(.IWIDTH(4), .DWIDTH(4), .AWIDTH(4)) dut (
    .CLK (CLK),
    .RST (RST),
    .bus (bus)
  );

  logic [7:0] rom [16];
  assign bus.PROG_DATA = rom[bus.PROG_ADDR];

  always_comb begin
    bus.ALU_OUT = 4'h0;
    case (bus.ALU_INSTR)
      4'd0:  bus.ALU_OUT = ~bus.ALU_A;
      4'd1:  bus.ALU_OUT = bus.ALU_A ^ bus.ALU_B;
      4'd2:  bus.ALU_OUT = bus.ALU_A | bus.ALU_B;
      4'd3:  bus.ALU_OUT = bus.ALU_A & bus.ALU_B;
      4'd4:  bus.ALU_OUT = bus.ALU_A - bus.ALU_B;
      4'd5:  bus.ALU_OUT = bus.ALU_A + bus.ALU_B;
      4'd6:  bus.ALU_OUT = {bus.ALU_A[0], bus.ALU_A[3:1]};
      4'd7:  bus.ALU_OUT = {bus.ALU_A[2:0], bus.ALU_A[3]};
      4'd8:  bus.ALU_OUT = bus.ALU_A - 4'd1;
      4'd9:  bus.ALU_OUT = bus.ALU_A + 4'd1;
      4'd10: bus.ALU_OUT = bus.ALU_B;
      default: bus.ALU_OUT = 4'h0;
    endcase
  end

  typedef struct {
    logic       start;
    logic       en;
    logic [3:0] addr;
    logic [3:0] acc;
    logic       zf;
    logic       halted;
  } vec_t;

  vec_t vq[$];
  int   n_tests = 0;
  int   n_fail  = 0;

  task automatic check(input string name, input int act, input int exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  function automatic void push(input logic s, input logic e, input int a,
                               input int acc, input logic z, input logic h);
    vec_t v;
    v.start = s; v.en = e; v.addr = 4'(a); v.acc = 4'(acc); v.zf = z; v.halted = h;
    vq.push_back(v);
  endfunction

  task automatic step(input logic s, input logic e);
    @(negedge CLK);
    bus.START = s;
    bus.EN    = e;
    @(posedge CLK);
    #1;
  endtask

  task automatic check_state(input string tag, input int a, input int acc,
                             input logic z, input logic h);
    check({tag, ".addr"},   int'(bus.PROG_ADDR), a);
    check({tag, ".acc"},    int'(bus.ACC), acc);
    check({tag, ".zf"},     int'(bus.ZF), int'(z));
    check({tag, ".halted"}, int'(bus.HALTED), int'(h));
    check({tag, ".alu_a"},  int'(bus.ALU_A), acc);
  endtask

  task automatic run_vecs(input string tag);
    for (int i = 0; i < vq.size(); i++) begin
      step(vq[i].start, vq[i].en);
      check_state($sformatf("%s.v%0d", tag, i), int'(vq[i].addr), int'(vq[i].acc),
                  vq[i].zf, vq[i].halted);
    end
    vq.delete();
  endtask

  task automatic fill_rom(input logic [7:0] w);
    for (int i = 0; i < 16; i++) rom[i] = w;
  endtask

  task automatic do_reset(input string tag);
    @(negedge CLK);
    bus.START = 1'b0;
    bus.EN    = 1'b1;
    RST = 1'b0;
    #2;
    check_state({tag, ".rst"}, 0, 0, 1'b0, 1'b0);
    @(negedge CLK);
    RST = 1'b1;
  endtask

  task automatic load_prog1();
    fill_rom(8'hD0);
    rom[0] = 8'hA3;  // LD 3
    rom[1] = 8'h55;  // ADD 5
    rom[2] = 8'hF0;  // HLT
  endtask

  initial begin
    RST = 1'b0;
    bus.START = 1'b0;
    bus.EN    = 1'b0;
    fill_rom(8'hD0);

    // Test 1 + stall + restart from HALT
    load_prog1();
    do_reset("t1");
    push(1, 1, 0, 0, 0, 0);
    push(0, 1, 1, 3, 0, 0);
    push(0, 0, 1, 3, 0, 0);
    push(0, 0, 1, 3, 0, 0);
    push(0, 0, 1, 3, 0, 0);
    push(0, 1, 2, 8, 0, 0);
    push(0, 1, 2, 8, 0, 1);
    for (int i = 0; i < 5; i++) push(0, 1, 2, 8, 0, 1);
    push(1, 1, 0, 8, 0, 0);
    push(0, 1, 1, 3, 0, 0);
    push(0, 1, 2, 8, 0, 0);
    push(0, 1, 2, 8, 0, 1);
    run_vecs("t1");

    // Test 2: LD 0 sets ZF, JZ taken
    fill_rom(8'hD0);
    rom[0] = 8'hA0;
    rom[1] = 8'hC6;
    rom[6] = 8'hF0;
    do_reset("t2");
    push(1, 1, 0, 0, 0, 0);
    push(0, 1, 1, 0, 1, 0);
    push(0, 1, 6, 0, 1, 0);
    push(0, 1, 6, 0, 1, 1);
    run_vecs("t2");

    // Test 3: JZ not taken, JMP to 15, PC wraps to 0
    fill_rom(8'h00);
    rom[0]  = 8'hA1;
    rom[1]  = 8'hC5;
    rom[2]  = 8'hBF;
    rom[15] = 8'hD0;
    do_reset("t3");
    push(1, 1, 0, 0, 0, 0);
    push(0, 1, 1, 1, 0, 0);
    push(0, 1, 2, 1, 0, 0);
    push(0, 1, 15, 1, 0, 0);
    push(0, 1, 0, 1, 0, 0);
    push(0, 1, 1, 1, 0, 0);
    run_vecs("t3");

    // Test 5: async reset between edges while PC=1
    load_prog1();
    do_reset("t5");
    push(1, 1, 0, 0, 0, 0);
    push(0, 1, 1, 3, 0, 0);
    run_vecs("t5a");
    #2;
    RST = 1'b0;
    #1;
    check_state("t5.async", 0, 0, 1'b0, 1'b0);
    @(negedge CLK);
    RST = 1'b1;
    push(0, 1, 0, 0, 0, 0);
    push(0, 1, 0, 0, 0, 0);
    push(0, 1, 0, 0, 0, 0);
    push(1, 1, 0, 0, 0, 0);
    push(0, 1, 1, 3, 0, 0);
    run_vecs("t5b");

    // INC wraps to zero, reserved opcode behaves as NOP with ALU_INSTR=0
    fill_rom(8'hD0);
    rom[0] = 8'hAF;  // LD 15
    rom[1] = 8'h90;  // INC
    rom[2] = 8'hE3;  // reserved
    rom[3] = 8'hF0;  // HLT
    do_reset("t7");
    push(1, 1, 0, 0, 0, 0);
    push(0, 1, 1, 15, 0, 0);
    push(0, 1, 2, 0, 1, 0);
    run_vecs("t7a");
    check("t7.rsv_instr", int'(bus.ALU_INSTR), 0);
    check("t7.rsv_b", int'(bus.ALU_B), 3);
    push(0, 1, 3, 0, 1, 0);
    push(0, 1, 3, 0, 1, 1);
    run_vecs("t7b");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/alu_sequencer.md
Name: alu_sequencer

Overview:
- Upstream control stage for the team's alu. Fetches one instruction per cycle from program memory, drives the alu's IN_INSTR/IN_A/IN_B, and writes the alu result back into an accumulator.
- Tracks a zero flag and executes jump, conditional-jump, no-op and halt instructions itself.
- Together with alu and a program ROM it forms the one-cycle CPU core.

Parameters:
- IWIDTH, 4, opcode width; must equal the alu IWIDTH.
- DWIDTH, 4, data/operand width; must equal the alu DWIDTH.
- AWIDTH, 4, program address width; AWIDTH <= DWIDTH.

Ports:
- CLK  input  1  system clock, rising-edge active.
- RST  input  1  asynchronous reset, active-low.
- START  input  1  level; starts or restarts execution (see FSM).
- EN  input  1  run enable; 0 stalls the core in RUN.
- PROG_ADDR  output  AWIDTH  program counter, to ROM address.
- PROG_DATA  input  IWIDTH+DWIDTH  instruction word: opcode [IWIDTH+DWIDTH-1:DWIDTH], operand [DWIDTH-1:0].
- ALU_INSTR  output  IWIDTH  to alu IN_INSTR.
- ALU_A  output  DWIDTH  to alu IN_A; always equals ACC.
- ALU_B  output  DWIDTH  to alu IN_B; always equals the operand.
- ALU_OUT  input  DWIDTH  from alu OUT.
- ACC  output  DWIDTH  accumulator register.
- ZF  output  1  zero flag register.
- HALTED  output  1  1 while in HALT.

Behaviour:
- Reset (RST=0, asynchronous): PC=0, ACC=0, ZF=0, state=IDLE, HALTED=0. Reset wins over every other event, including mid-instruction.
- Opcode map:
  - 0000-1010: alu ops (NOT, XOR, OR, AND, SUB, ADD, RR, RL, DEC, INC, LD).
  - 1011: JMP.
  - 1100: JZ.
  - 1101: NOP.
  - 1110: reserved, executes as NOP.
  - 1111: HLT.
- ALU_INSTR is combinational: equals the opcode when the opcode <= 1010, else 0000. The alu output is ignored for non-alu opcodes.
- FSM states: IDLE, RUN, HALT.
  - IDLE: PC, ACC and ZF hold. START=1 -> RUN at the next edge.
  - RUN with EN=0: everything holds (stall); no write-back.
  - RUN with EN=1: executes the instruction at PROG_ADDR in that cycle; results are registered at the rising edge.
  - HALT: HALTED=1; PC stays at the HLT address; ACC and ZF hold. START=1 -> PC=0, state RUN; ACC and ZF are retained.
- Execution in RUN with EN=1 (single-cycle; latency from PROG_DATA to ACC is one edge):
  - alu op: ACC <= ALU_OUT; ZF <= (ALU_OUT == 0); PC <= PC+1.
  - JMP: PC <= operand[AWIDTH-1:0]; ACC and ZF unchanged.
  - JZ: PC <= operand[AWIDTH-1:0] if ZF=1, else PC+1. Uses the ZF value registered before this instruction.
  - NOP / reserved: PC <= PC+1.
  - HLT: state <= HALT; PC unchanged.
- PC arithmetic is modulo 2^AWIDTH: 2^AWIDTH-1 + 1 wraps to 0 with no flag.
- Arithmetic width: ACC takes ALU_OUT unmodified (DWIDTH bits). Any carry is the alu's concern and is not tracked.
- START held high in RUN has no effect.
- The core is purely synchronous apart from RST; ROM reads are combinational, with the data valid in the same cycle.

Test Plan:
- 1. Basic run. ROM {0: LD 3, 1: ADD 5, 2: HLT}; release reset; pulse START.
  - After the edge executing addr 0: ACC=3.
  - After addr 1: ACC=8, ZF=0.
  - After addr 2: HALTED=1, PROG_ADDR stays 2 for 5 further cycles.
- 2. Zero flag and JZ taken. ROM {0: LD 0, 1: JZ 6, 6: HLT}.
  - After addr 0: ZF=1.
  - PROG_ADDR sequence: 0, 1, 6; then HALTED=1, ACC=0.
- 3. JZ not taken and wrap. ROM {0: LD 1, 1: JZ 5, 2: JMP 15, 15: NOP, 0 ...}.
  - PROG_ADDR sequence: 0, 1, 2, 15, 0.
  - ZF=0 throughout; ACC=1.
- 4. Stall. During test 1, hold EN=0 for 3 cycles after addr 0 executes.
  - PROG_ADDR stays 1 and ACC stays 3 for those cycles.
  - EN=1 resumes: ACC=8 at the next edge.
- 5. Async reset mid-run. Assert RST=0 between clock edges while PROG_ADDR=1 in test 1.
  - PROG_ADDR=0, ACC=0, ZF=0, HALTED=0 immediately, without waiting for an edge.
  - After release, the core stays IDLE until START.
- 6. Restart from HALT. After test 1 halts, pulse START.
  - PROG_ADDR=0, HALTED=0.
  - ACC=8 before addr 0 executes; re-execution yields ACC=3, then 8, then halts again.
